// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and request types for the 1RW+1R SRAM initiator.
package sram_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_NUM_WMASKS = 8;
    localparam int DEF_RESP_DEPTH = 3;

    // Port-0 request payload at default widths.
    typedef struct packed {
        logic                      we;
        logic [DEF_NUM_WMASKS-1:0] wmask;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } p0_req_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Small valid/ready response buffer; outputs are forced idle while reset is high.
module sram_resp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_valid = (count != '0) && !rst;
    assign pop_data  = pop_valid ? mem[rd_ptr] : '0;
    assign pop       = pop_valid && pop_ready;

    // Upstream credit logic guarantees push never hits a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_valid) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            case ({push_valid, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_1rw1r_initiator.sv
// Valid/ready front end for a 1RW+1R synchronous SRAM with credit-limited,
// in-order read response buffering per port.
module sram_1rw1r_initiator
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS,
    parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [NUM_WMASKS-1:0] p0_req_wmask,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_resp_valid,
    input  logic                  p0_resp_ready,
    output logic [DATA_WIDTH-1:0] p0_resp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    output logic                  p1_resp_valid,
    input  logic                  p1_resp_ready,
    output logic [DATA_WIDTH-1:0] p1_resp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic          p0_fire, p1_fire, p1_hazard;
    logic          p0_rd_pend, p1_rd_pend;
    logic [CW-1:0] p0_fifo_cnt, p1_fifo_cnt, p0_credits, p1_credits;

    // Credits come only from registered state, so resp_ready never reaches req_ready.
    assign p0_credits = p0_fifo_cnt + CW'(p0_rd_pend);
    assign p1_credits = p1_fifo_cnt + CW'(p1_rd_pend);

    // A p1 read racing a p0 write to the same word would see stale array data.
    assign p1_hazard    = p0_fire && p0_req_we && (p1_req_addr == p0_req_addr);
    assign p0_req_ready = !rst && (p0_credits < CW'(RESP_DEPTH));
    assign p1_req_ready = !rst && (p1_credits < CW'(RESP_DEPTH)) && !p1_hazard;
    assign p0_fire      = p0_req_valid && p0_req_ready;
    assign p1_fire      = p1_req_valid && p1_req_ready;

    always_comb begin
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        addr0  = '0;
        din0   = '0;
        if (p0_fire) begin
            csb0   = 1'b0;
            web0   = !p0_req_we;
            wmask0 = p0_req_wmask;
            addr0  = p0_req_addr;
            din0   = p0_req_wdata;
        end
    end

    always_comb begin
        csb1  = 1'b1;
        addr1 = '0;
        if (p1_fire) begin
            csb1  = 1'b0;
            addr1 = p1_req_addr;
        end
    end

    // dout is valid for one cycle after the SRAM latches the read address.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rd_pend <= 1'b0;
            p1_rd_pend <= 1'b0;
        end else begin
            p0_rd_pend <= p0_fire && !p0_req_we;
            p1_rd_pend <= p1_fire;
        end
    end

    sram_resp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RESP_DEPTH), .CW(CW)) u_p0_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (p0_rd_pend),
        .push_data  (dout0),
        .pop_valid  (p0_resp_valid),
        .pop_ready  (p0_resp_ready),
        .pop_data   (p0_resp_rdata),
        .count      (p0_fifo_cnt)
    );

    sram_resp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RESP_DEPTH), .CW(CW)) u_p1_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (p1_rd_pend),
        .push_data  (dout1),
        .pop_valid  (p1_resp_valid),
        .pop_ready  (p1_resp_ready),
        .pop_data   (p1_resp_rdata),
        .count      (p1_fifo_cnt)
    );

endmodule

// File: tb/tb_sram_1rw1r_initiator.sv
// Directed bench for sram_1rw1r_initiator with a behavioural 1RW+1R SRAM attached.
module tb_sram_1rw1r_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req_valid, p0_req_ready, p0_req_we;
    logic [7:0]  p0_req_wmask, p0_req_addr;
    logic [63:0] p0_req_wdata;
    logic        p0_resp_valid, p0_resp_ready;
    logic [63:0] p0_resp_rdata;
    logic        p1_req_valid, p1_req_ready;
    logic [7:0]  p1_req_addr;
    logic        p1_resp_valid, p1_resp_ready;
    logic [63:0] p1_resp_rdata;
    logic        csb0, web0, csb1;
    logic [7:0]  wmask0, addr0, addr1;
    logic [63:0] din0, dout0, dout1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    sram_1rw1r_initiator dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_wmask(p0_req_wmask), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready), .p0_resp_rdata(p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
        .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready), .p1_resp_rdata(p1_resp_rdata),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .csb1(csb1), .addr1(addr1), .dout1(dout1)
    );

    // Behavioural SRAM: registered read data, byte-masked writes.
    logic [63:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        dout0 = '0;
        dout1 = '0;
    end
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 8; b++)
                    if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
            end else begin
                dout0 <= mem[addr0];
            end
        end
        if (!csb1) dout1 <= mem[addr1];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic p0_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] m);
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = a; p0_req_wdata = d; p0_req_wmask = m;
        tick();
        p0_req_valid = 1'b0; p0_req_we = 1'b0;
    endtask

    task automatic p0_read(input logic [7:0] a, output logic [63:0] d, output bit ok);
        p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = a;
        tick();
        p0_req_valid = 1'b0;
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (p0_resp_valid) begin
                d = p0_resp_rdata; ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            p0_resp_ready = 1'b1;
            tick();
            p0_resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 8'h55; p0_req_wmask = 8'hFF;
        p0_req_wdata = 64'h1; p1_req_valid = 1'b1; p1_req_addr = 8'h66;
        p0_resp_ready = 1'b0; p1_resp_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        vectors++; if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin errors++;
            $display("FAIL rst_req_ready: got %b%b want 00", p0_req_ready, p1_req_ready); end
        vectors++; if (p0_resp_valid !== 1'b0 || p1_resp_valid !== 1'b0) begin errors++;
            $display("FAIL rst_resp_valid: got %b%b want 00", p0_resp_valid, p1_resp_valid); end
        vectors++; if (csb0 !== 1'b1 || web0 !== 1'b1 || csb1 !== 1'b1 || addr0 !== 8'h0 ||
                       addr1 !== 8'h0 || din0 !== 64'h0 || wmask0 !== 8'h0) begin errors++;
            $display("FAIL rst_sram_idle: csb0=%b web0=%b csb1=%b addr0=%h addr1=%h want idle",
                     csb0, web0, csb1, addr0, addr1); end
        vectors++; if (p0_resp_rdata !== 64'h0 || p1_resp_rdata !== 64'h0) begin errors++;
            $display("FAIL rst_rdata: got %h %h want 0", p0_resp_rdata, p1_resp_rdata); end
        tick();
        rst = 1'b0; p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        @(negedge clk);
        vectors++; if (p0_req_ready !== 1'b1 || p1_req_ready !== 1'b1) begin errors++;
            $display("FAIL post_rst_ready: got %b%b want 11", p0_req_ready, p1_req_ready); end
        tick();
    endtask

    task automatic test_write_read;
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 8'h10;
        p0_req_wdata = 64'h0123456789ABCDEF; p0_req_wmask = 8'hFF;
        @(negedge clk);
        vectors++; if (csb0 !== 1'b0 || web0 !== 1'b0 || addr0 !== 8'h10 || wmask0 !== 8'hFF ||
                       din0 !== 64'h0123456789ABCDEF) begin errors++;
            $display("FAIL wr_drive: csb0=%b web0=%b addr0=%h wmask0=%h din0=%h", csb0, web0, addr0, wmask0, din0); end
        tick();
        p0_req_we = 1'b0;
        @(negedge clk);
        vectors++; if (csb0 !== 1'b0 || web0 !== 1'b1 || addr0 !== 8'h10) begin errors++;
            $display("FAIL rd_drive: csb0=%b web0=%b addr0=%h want 0 1 10", csb0, web0, addr0); end
        tick();
        p0_req_valid = 1'b0;
        @(negedge clk);
        vectors++; if (p0_resp_valid !== 1'b0 || csb0 !== 1'b1 || addr0 !== 8'h0) begin errors++;
            $display("FAIL rd_n1: resp_valid=%b csb0=%b addr0=%h want 0 1 00", p0_resp_valid, csb0, addr0); end
        tick();
        @(negedge clk);
        vectors++; if (p0_resp_valid !== 1'b1 || p0_resp_rdata !== 64'h0123456789ABCDEF) begin errors++;
            $display("FAIL rd_n2: valid=%b rdata=%h want 1 0123456789abcdef", p0_resp_valid, p0_resp_rdata); end
        tick();
        @(negedge clk);
        vectors++; if (p0_resp_valid !== 1'b1 || p0_resp_rdata !== 64'h0123456789ABCDEF) begin errors++;
            $display("FAIL rd_hold: valid=%b rdata=%h want held", p0_resp_valid, p0_resp_rdata); end
        p0_resp_ready = 1'b1;
        tick();
        p0_resp_ready = 1'b0;
        @(negedge clk);
        vectors++; if (p0_resp_valid !== 1'b0) begin errors++;
            $display("FAIL rd_pop: valid=%b want 0", p0_resp_valid); end
        tick();
    endtask

    task automatic test_mask;
        logic [63:0] d;
        bit ok;
        p0_write(8'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        p0_write(8'h20, 64'h0, 8'h0F);
        p0_read(8'h20, d, ok);
        vectors++; if (!ok || d !== 64'hFFFFFFFF00000000) begin errors++;
            $display("FAIL mask_read: ok=%0d got %h want ffffffff00000000", ok, d); end
        // zero-mask write still reaches the array but changes nothing
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 8'h20; p0_req_wdata = 64'h1234; p0_req_wmask = 8'h00;
        @(negedge clk);
        vectors++; if (csb0 !== 1'b0 || web0 !== 1'b0) begin errors++;
            $display("FAIL mask0_issue: csb0=%b web0=%b want 0 0", csb0, web0); end
        tick();
        p0_req_valid = 1'b0; p0_req_we = 1'b0;
        p0_read(8'h20, d, ok);
        vectors++; if (!ok || d !== 64'hFFFFFFFF00000000) begin errors++;
            $display("FAIL mask0_read: ok=%0d got %h want ffffffff00000000", ok, d); end
    endtask

    task automatic test_hazard;
        logic [63:0] got [2];
        int n;
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 8'h30; p0_req_wdata = 64'hA5A5; p0_req_wmask = 8'hFF;
        p1_req_valid = 1'b1; p1_req_addr = 8'h30;
        @(negedge clk);
        vectors++; if (p1_req_ready !== 1'b0 || p0_req_ready !== 1'b1 || csb1 !== 1'b1) begin errors++;
            $display("FAIL hazard_stall: p1_ready=%b p0_ready=%b csb1=%b want 0 1 1", p1_req_ready, p0_req_ready, csb1); end
        tick();
        p0_req_valid = 1'b0; p0_req_we = 1'b0;
        @(negedge clk);
        vectors++; if (p1_req_ready !== 1'b1 || csb1 !== 1'b0 || addr1 !== 8'h30) begin errors++;
            $display("FAIL hazard_issue: p1_ready=%b csb1=%b addr1=%h want 1 0 30", p1_req_ready, csb1, addr1); end
        tick();
        p1_req_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 8 && n == 0; i++) begin
            @(negedge clk);
            if (p1_resp_valid) begin got[0] = p1_resp_rdata; n = 1; end
            p1_resp_ready = p1_resp_valid;
            tick();
        end
        p1_resp_ready = 1'b0;
        vectors++; if (n != 1 || got[0] !== 64'hA5A5) begin errors++;
            $display("FAIL hazard_data: n=%0d got %h want a5a5", n, got[0]); end
        // different address: no stall; then a p1 read right after the write sees new data
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 8'h31; p0_req_wdata = 64'h5A; p0_req_wmask = 8'hFF;
        p1_req_valid = 1'b1; p1_req_addr = 8'h30;
        @(negedge clk);
        vectors++; if (p1_req_ready !== 1'b1) begin errors++;
            $display("FAIL nohazard_ready: got %b want 1", p1_req_ready); end
        tick();
        p0_req_valid = 1'b0; p0_req_we = 1'b0; p1_req_addr = 8'h31;
        tick();
        p1_req_valid = 1'b0; p1_resp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && n < 2; i++) begin
            @(negedge clk);
            if (p1_resp_valid) begin got[n] = p1_resp_rdata; n++; end
            tick();
        end
        p1_resp_ready = 1'b0;
        vectors++; if (n != 2 || got[0] !== 64'hA5A5 || got[1] !== 64'h5A) begin errors++;
            $display("FAIL raw_nextcycle: n=%0d got %h %h want a5a5 5a", n, got[0], got[1]); end
    endtask

    task automatic test_back_to_back;
        int bad_rdy, bad_rsp;
        for (int i = 0; i < 16; i++) p0_write(8'(i), 64'hB000000000000000 | 64'(i), 8'hFF);
        p1_resp_ready = 1'b1;
        bad_rdy = 0; bad_rsp = 0;
        for (int c = 0; c < 18; c++) begin
            p1_req_valid = (c < 16);
            p1_req_addr  = 8'(c);
            @(negedge clk);
            if (c < 16 && p1_req_ready !== 1'b1) bad_rdy++;
            if (c >= 2 && (p1_resp_valid !== 1'b1 ||
                           p1_resp_rdata !== (64'hB000000000000000 | 64'(c - 2)))) begin
                bad_rsp++;
                $display("FAIL b2b_resp[%0d]: valid=%b rdata=%h", c - 2, p1_resp_valid, p1_resp_rdata);
            end
            tick();
        end
        p1_req_valid = 1'b0;
        vectors++; if (bad_rdy != 0) begin errors++;
            $display("FAIL b2b_ready: %0d stalled cycles want 0", bad_rdy); end
        vectors++; if (bad_rsp != 0) begin errors++;
            $display("FAIL b2b_stream: %0d bad responses want 0", bad_rsp); end
        @(negedge clk);
        vectors++; if (p1_resp_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_drained: valid=%b want 0", p1_resp_valid); end
        tick();
        // backpressure: only RESP_DEPTH reads may be outstanding
        p1_resp_ready = 1'b0;
        for (int c = 0, idx = 0; c < 6; c++) begin
            p1_req_valid = 1'b1;
            p1_req_addr  = 8'(idx);
            @(negedge clk);
            vectors++; if (p1_req_ready !== (c < 3)) begin errors++;
                $display("FAIL bp_ready[%0d]: got %b want %b", c, p1_req_ready, (c < 3)); end
            if (p1_req_ready) idx++;
            tick();
        end
        p1_req_valid = 1'b0;
        p1_resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++; if (p1_resp_valid !== 1'b1 || p1_resp_rdata !== (64'hB000000000000000 | 64'(k))) begin errors++;
                $display("FAIL bp_drain[%0d]: valid=%b rdata=%h", k, p1_resp_valid, p1_resp_rdata); end
            tick();
        end
        @(negedge clk);
        vectors++; if (p1_resp_valid !== 1'b0 || p1_req_ready !== 1'b1) begin errors++;
            $display("FAIL bp_after: valid=%b ready=%b want 0 1", p1_resp_valid, p1_req_ready); end
        p1_resp_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_midflight;
        logic [63:0] d;
        bit ok;
        int leaked;
        p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 8'h10;
        p1_req_valid = 1'b1; p1_req_addr = 8'h00;
        tick();
        p0_req_addr = 8'h20; p1_req_addr = 8'h01;
        tick();
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (p0_resp_valid !== 1'b0 || p1_resp_valid !== 1'b0 ||
                       p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin errors++;
            $display("FAIL midrst_during: resp_valid=%b%b req_ready=%b%b want 0000",
                     p0_resp_valid, p1_resp_valid, p0_req_ready, p1_req_ready); end
        tick();
        rst = 1'b0;
        leaked = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (p0_resp_valid !== 1'b0 || p1_resp_valid !== 1'b0) leaked++;
            tick();
        end
        vectors++; if (leaked != 0) begin errors++;
            $display("FAIL midrst_leak: %0d cycles with stale resp_valid want 0", leaked); end
        p0_read(8'h10, d, ok);
        vectors++; if (!ok || d !== 64'h0123456789ABCDEF) begin errors++;
            $display("FAIL midrst_newread: ok=%0d got %h want 0123456789abcdef", ok, d); end
    endtask

    initial begin
        rst = 1'b1;
        p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_wmask = '0; p0_req_addr = '0; p0_req_wdata = '0;
        p1_req_valid = 1'b0; p1_req_addr = '0; p0_resp_ready = 1'b0; p1_resp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_mask();
        test_hazard();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
